// File: rtl/fq_pkg.sv
// fq_pkg: shared types and defaults for the fetch queue.
//   FQ_DEPTH_DEF : default number of queue entries (power of two, >= 2)
//   PC_W_DEF     : default PC width (taken from `PC_SIZE, 16 if undefined)
//   INSTR_W_DEF  : default instruction word width
//   fq_entry_t   : one queue entry {pc, instr, pred_taken}
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package fq_pkg;
  localparam int FQ_DEPTH_DEF = 8;
  localparam int PC_W_DEF     = `PC_SIZE;
  localparam int INSTR_W_DEF  = 16;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic                   pred_taken;
  } fq_entry_t;
endpackage

// File: rtl/fq_ptr_ctrl.sv
// fq_ptr_ctrl: head/tail/count bookkeeping for the fetch queue.
//   clk, n_rst        : clock, synchronous active-high reset
//   in_valid          : fetch offers an entry
//   out_ready         : decode consumes the head
//   flush             : squash all entries
//   push, pop         : qualified enqueue / dequeue strobes
//   head, tail        : read / write slot indices
//   count             : occupancy
//   in_ready          : room for one more entry (registered state only)
//   out_valid         : head entry is valid
//   almost_full       : count >= FQ_DEPTH-1
import fq_pkg::*;

module fq_ptr_ctrl #(
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  localparam int PW = $clog2(FQ_DEPTH),
  localparam int CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          in_ready,
  output logic          out_valid,
  output logic          almost_full
);
  localparam logic [CW-1:0] FULL  = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(FQ_DEPTH - 1);

  assign in_ready    = (count != FULL);
  assign out_valid   = (count != '0);
  assign almost_full = (count >= AFULL);
  // Flush wins over both handshakes; the dropped beats are fetch's problem.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (n_rst)
    count <= FULL);
  a_ptr_consistent : assert property (@(posedge clk) disable iff (n_rst)
    tail == PW'(head + count[PW-1:0]));
  a_no_push_full : assert property (@(posedge clk) disable iff (n_rst)
    !(push && count == FULL));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode/rename.
//   clk, n_rst                       : clock, synchronous active-high reset
//   in_valid/in_ready                : enqueue handshake from fetch
//   in_pc, in_instr, in_pred_taken   : entry being fetched
//   out_valid/out_ready              : dequeue handshake toward decode
//   out_pc, out_instr, out_pred_taken: head entry (combinational from storage)
//   flush                            : mispredict squash, empties the queue
//   count, almost_full               : occupancy and fetch throttle hint
// PC_W / INSTR_W must match the widths baked into fq_entry_t.
import fq_pkg::*;

module fetch_queue #(
  parameter int FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  localparam int PW = $clog2(FQ_DEPTH),
  localparam int CW = $clog2(FQ_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_pred_taken,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_pred_taken,
  input  logic               flush,
  output logic [CW-1:0]      count,
  output logic               almost_full
);
  logic          push, pop;
  logic [PW-1:0] head, tail;
  fq_entry_t     mem [FQ_DEPTH];
  fq_entry_t     wr_entry, rd_entry;

  fq_ptr_ctrl #(.FQ_DEPTH(FQ_DEPTH)) u_ptr (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .almost_full(almost_full)
  );

  assign wr_entry = '{pc: in_pc, instr: in_instr, pred_taken: in_pred_taken};

  // Storage is cleared on reset so the outputs read 0 rather than X.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= wr_entry;
    end
  end

  // No empty bypass: a new entry shows up the cycle after it is written.
  assign rd_entry       = mem[head];
  assign out_pc         = rd_entry.pc;
  assign out_instr      = rd_entry.instr;
  assign out_pred_taken = rd_entry.pred_taken;
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage (fetch_unit, i_cache, branch_predictor) and decode/rename.
- Absorbs decode stalls caused by a full ROB, free-register list or execution buffer, so fetch keeps running until the queue fills.
- Stores {pc, instr, pred_taken} per entry, in order.
- The hazard controller flushes it on a branch mispredict.

Parameters:
- FQ_DEPTH, 8, number of entries; must be a power of two, at least 2.
- PC_W, `PC_SIZE, PC width.
- INSTR_W, 16, instruction word width.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_pc  in  PC_W  PC of the fetched instruction.
- in_instr  in  INSTR_W  instruction word from i_cache.
- in_pred_taken  in  1  branch_predictor outcome.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode/rename consumes the head this cycle.
- out_pc  out  PC_W  head PC.
- out_instr  out  INSTR_W  head instruction.
- out_pred_taken  out  1  head prediction.
- flush  in  1  hazard controller squash; discards all entries.
- count  out  $clog2(FQ_DEPTH)+1  current occupancy.
- almost_full  out  1  count >= FQ_DEPTH-1; fetch throttle hint.

Behaviour:
- Storage
  - Circular buffer with head pointer, tail pointer and count registers.
  - Pointers are $clog2(FQ_DEPTH) bits and wrap naturally from FQ_DEPTH-1 to 0.
- Reset (n_rst=1 at a clk edge)
  - head=0, tail=0, count=0.
  - Consequently out_valid=0, in_ready=1, almost_full=0, count=0.
  - out_pc, out_instr and out_pred_taken read 0: entry storage is reset to 0.
  - Reset overrides flush, push and pop in the same cycle.
- Push
  - push = in_valid & in_ready & ~flush.
  - Writes the entry at tail, then tail+1.
- Pop
  - pop = out_valid & out_ready & ~flush.
  - Advances head to head+1.
- Ready and valid
  - in_ready = (count != FQ_DEPTH). It depends only on registered state and never on out_ready, so there is no combinational ready loop.
  - out_valid = (count != 0).
  - out_* are driven combinationally from the storage entry at head.
- Latency
  - An entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
  - There is no same-cycle bypass when empty.
- Count update
  - count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged; this is legal at any non-empty, non-full occupancy.
- Full
  - When count=FQ_DEPTH, in_ready=0 even if out_ready=1 in the same cycle.
  - The slot freed by that pop is reusable the following cycle.
- Empty
  - out_valid=0. out_ready is ignored and there is no pop.
- Flush
  - Next cycle: head=tail=0, count=0.
  - Any push or pop in the flush cycle is dropped: the same-cycle in_valid is not enqueued and the head is not consumed.
  - in_ready remains as computed from count during the flush cycle. Fetch must treat the flush as its own redirect and not rely on acceptance.
- Stability
  - While out_valid=1 and out_ready=0, out_* hold constant.
  - Pushes never modify the head entry, because tail != head whenever count != 0 and count != FQ_DEPTH.
- Assertions (simulation only)
  - count <= FQ_DEPTH at all times.
  - tail == head+count mod FQ_DEPTH.
  - No push when count == FQ_DEPTH.

Decomposition:
- Shared package fq_pkg:
  - fq_entry_t struct {logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; logic pred_taken;}.
  - FQ_DEPTH default constant.
- Sub-module fq_ptr_ctrl: holds head, tail and count registers, and computes push, pop, flush, in_ready, out_valid and almost_full.
- fetch_queue instantiates fq_ptr_ctrl plus the entry array.

Test Plan:
- Reset/basic: after reset, push pc=0x0010 instr=0x1234 pred=1 in cycle 1 with out_ready=0.
  - Cycle 2: out_valid=1, out_pc=0x0010, out_instr=0x1234, out_pred_taken=1, count=1.
  - Cycle 1: out_valid=0.
- Fill/full: push 8 entries pc=0..7 with out_ready=0.
  - After the 8th: in_ready=0, count=8, almost_full=1.
  - A 9th in_valid is not accepted; draining yields pc 0..7 in order.
- Full with pop: at count=8, assert in_valid=1 and out_ready=1 in one cycle.
  - Pop occurs, push does not; count=7.
  - Next cycle the push is accepted and count=8.
- Wrap-around: run 20 consecutive push+pop cycles with the queue holding 3 entries.
  - Outputs come out in PC order across pointer wrap; count stays 3.
- Flush: with count=5, assert flush together with in_valid=1 and out_ready=1.
  - Next cycle: count=0, out_valid=0, no entry enqueued.
  - The following push pc=0x0040 appears as the head.
- Reset mid-operation: count=4, then n_rst=1 for one cycle together with in_valid=1.
  - Next cycle: count=0, out_valid=0, in_ready=1.
